// File: rtl/axis_stream_join_pkg.sv
// Shared widths, conv tuser bit indices and pointer helper for the stream join.
package axis_stream_join_pkg;

   localparam int unsigned WORD_WIDTH = 8;
   localparam int unsigned UNITS      = 8;
   localparam int unsigned COPIES     = 2;

   localparam int unsigned NUM_S_DEF  = COPIES;
   localparam int unsigned DATA_W_DEF = UNITS * WORD_WIDTH;
   localparam int unsigned USER_W_DEF = 16;

   // Conv-engine tuser bit positions
   localparam int unsigned USER_TOP_BLOCK = 0;
   localparam int unsigned USER_BOT_BLOCK = 1;
   localparam int unsigned USER_COLS_1_K2 = 2;
   localparam int unsigned USER_CIN_LAST  = 3;
   localparam int unsigned USER_W_FIRST   = 4;
   localparam int unsigned USER_COL_VALID = 5;
   localparam int unsigned USER_SUM_START = 6;

   localparam logic [USER_W_DEF-1:0] CONV_GATE_MASK =
      (USER_W_DEF'(1) << USER_TOP_BLOCK) | (USER_W_DEF'(1) << USER_BOT_BLOCK) |
      (USER_W_DEF'(1) << USER_COLS_1_K2) | (USER_W_DEF'(1) << USER_CIN_LAST)  |
      (USER_W_DEF'(1) << USER_W_FIRST)   | (USER_W_DEF'(1) << USER_COL_VALID) |
      (USER_W_DEF'(1) << USER_SUM_START);

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(v)) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/axis_join_fifo.sv
// Per-stream decoupling FIFO with a registered ready derived from the next occupancy.
module axis_join_fifo
   import axis_stream_join_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_payload,
   input  logic             pop,
   output logic [WIDTH-1:0] m_payload,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic             push;
   logic             pop_ok;

   assign push      = s_valid && s_ready;
   assign pop_ok    = pop && !empty;
   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign m_payload = mem[rd_ptr];

   always_comb begin
      count_nxt = count;
      if (push && !pop_ok)      count_nxt = count + CW'(1);
      else if (!push && pop_ok) count_nxt = count - CW'(1);
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= s_payload;
   end

   // Ready looks one cycle behind a pop, so a full FIFO never turns ready combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         s_ready <= 1'b0;
      end else begin
         if (push)   wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
         count   <= count_nxt;
         s_ready <= (count_nxt != CW'(DEPTH));
      end
   end

endmodule

// File: rtl/axis_stream_join.sv
// Joins NUM_S AXI-Stream inputs into one registered output beat, all-or-nothing per beat.
module axis_stream_join
   import axis_stream_join_pkg::*;
#(
   parameter int unsigned       NUM_S      = NUM_S_DEF,
   parameter int unsigned       DATA_W     = DATA_W_DEF,
   parameter int unsigned       USER_W     = USER_W_DEF,
   parameter int unsigned       FIFO_DEPTH = 4,
   parameter int unsigned       LAST_SRC   = 1,
   parameter int unsigned       LAST_CHECK = 1,
   parameter logic [USER_W-1:0] GATE_MASK  = '0,
   parameter int unsigned       CNT_W      = 32
) (
   input  logic                      aclk,
   input  logic                      areset,
   input  logic [NUM_S-1:0]          s_valid,
   output logic [NUM_S-1:0]          s_ready,
   input  logic [NUM_S-1:0]          s_last,
   input  logic [NUM_S*DATA_W-1:0]   s_data,
   input  logic [NUM_S*USER_W-1:0]   s_user,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic                      m_last,
   output logic [NUM_S*DATA_W-1:0]   m_data,
   output logic [NUM_S*USER_W-1:0]   m_user,
   output logic                      err_last_mismatch,
   output logic [CNT_W-1:0]          beat_count
);

   localparam int unsigned PW = 1 + USER_W + DATA_W;

   logic [NUM_S-1:0]        full;
   logic [NUM_S-1:0]        empty;
   logic [NUM_S-1:0]        pop_last;
   logic [NUM_S*DATA_W-1:0] pop_data;
   logic [NUM_S*USER_W-1:0] pop_user;
   logic [NUM_S*USER_W-1:0] m_user_q;
   logic [NUM_S*USER_W-1:0] gate;
   logic                    fire;
   logic                    mismatch;
   logic                    unused_full;

   for (genvar k = 0; k < NUM_S; k++) begin : g_fifo
      logic [PW-1:0] out_w;

      axis_join_fifo #(
         .WIDTH (PW),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk       (aclk),
         .rst       (areset),
         .s_valid   (s_valid[k]),
         .s_ready   (s_ready[k]),
         .s_payload ({s_last[k], s_user[k*USER_W +: USER_W], s_data[k*DATA_W +: DATA_W]}),
         .pop       (fire),
         .m_payload (out_w),
         .full      (full[k]),
         .empty     (empty[k])
      );

      assign pop_last[k]                  = out_w[PW-1];
      assign pop_user[k*USER_W +: USER_W] = out_w[DATA_W +: USER_W];
      assign pop_data[k*DATA_W +: DATA_W] = out_w[DATA_W-1:0];
      assign gate[k*USER_W +: USER_W]     = GATE_MASK;
   end

   assign unused_full = ^full;

   assign fire     = (&(~empty)) && (!m_valid || m_ready);
   assign mismatch = (LAST_CHECK != 0) && (|pop_last) && !(&pop_last);

   // Gated tuser bits only show while the beat is valid.
   assign m_user = m_user_q & ~(gate & {(NUM_S*USER_W){~m_valid}});

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         m_valid           <= 1'b0;
         m_last            <= 1'b0;
         m_data            <= '0;
         m_user_q          <= '0;
         err_last_mismatch <= 1'b0;
         beat_count        <= '0;
      end else begin
         if (fire) begin
            m_valid  <= 1'b1;
            m_last   <= pop_last[LAST_SRC];
            m_data   <= pop_data;
            m_user_q <= pop_user;
            if (mismatch) err_last_mismatch <= 1'b1;
         end else if (m_valid && m_ready) begin
            m_valid <= 1'b0;
         end
         if (m_valid && m_ready) beat_count <= beat_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_axis_stream_join.sv
// Directed bench for axis_stream_join: two streams, tuser bit 3 gated, tlast from stream 1.
module tb_axis_stream_join;

   localparam int unsigned NUM_S  = 2;
   localparam int unsigned DATA_W = 64;
   localparam int unsigned USER_W = 16;
   localparam int unsigned CNT_W  = 32;

   logic                    aclk = 1'b0;
   logic                    areset;
   logic [NUM_S-1:0]        s_valid;
   logic [NUM_S-1:0]        s_ready;
   logic [NUM_S-1:0]        s_last;
   logic [NUM_S*DATA_W-1:0] s_data;
   logic [NUM_S*USER_W-1:0] s_user;
   logic                    m_valid;
   logic                    m_ready;
   logic                    m_last;
   logic [NUM_S*DATA_W-1:0] m_data;
   logic [NUM_S*USER_W-1:0] m_user;
   logic                    err_last_mismatch;
   logic [CNT_W-1:0]        beat_count;

   int tests = 0;
   int fails = 0;

   axis_stream_join #(
      .NUM_S      (NUM_S),
      .DATA_W     (DATA_W),
      .USER_W     (USER_W),
      .FIFO_DEPTH (4),
      .LAST_SRC   (1),
      .LAST_CHECK (1),
      .GATE_MASK  (16'h0008),
      .CNT_W      (CNT_W)
   ) dut (
      .aclk              (aclk),
      .areset            (areset),
      .s_valid           (s_valid),
      .s_ready           (s_ready),
      .s_last            (s_last),
      .s_data            (s_data),
      .s_user            (s_user),
      .m_valid           (m_valid),
      .m_ready           (m_ready),
      .m_last            (m_last),
      .m_data            (m_data),
      .m_user            (m_user),
      .err_last_mismatch (err_last_mismatch),
      .beat_count        (beat_count)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic drive(input logic [1:0] v, input logic [1:0] l,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [15:0] u0, input logic [15:0] u1);
      s_valid = v;
      s_last  = l;
      s_data  = {d1, d0};
      s_user  = {u1, u0};
   endtask

   initial begin
      logic [63:0] ea;
      logic [63:0] eb;

      areset  = 1'b1;
      m_ready = 1'b0;
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);

      // Reset state
      #2;
      check("rst_m_valid", 128'(m_valid), 128'(0));
      check("rst_m_last", 128'(m_last), 128'(0));
      check("rst_m_data", 128'(m_data), 128'(0));
      check("rst_m_user", 128'(m_user), 128'(0));
      check("rst_err", 128'(err_last_mismatch), 128'(0));
      check("rst_count", 128'(beat_count), 128'(0));
      step();
      check("rst_s_ready", 128'(s_ready), 128'(2'b00));
      areset = 1'b0;
      step();
      check("release_s_ready", 128'(s_ready), 128'(2'b11));

      // Single beat on both streams
      m_ready = 1'b1;
      drive(2'b11, 2'b00, 64'h11, 64'h22, 16'h0009, 16'h00F8);
      step();
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      check("single_no_valid_yet", 128'(m_valid), 128'(0));
      step();
      check("single_valid", 128'(m_valid), 128'(1));
      check("single_data", 128'(m_data), {64'h22, 64'h11});
      check("single_user_valid", 128'(m_user), 128'({16'h00F8, 16'h0009}));
      check("single_count_before", 128'(beat_count), 128'(0));
      step();
      check("single_count_after", 128'(beat_count), 128'(1));
      check("single_valid_clear", 128'(m_valid), 128'(0));
      check("gated_user_idle", 128'(m_user), 128'({16'h00F0, 16'h0001}));

      // Skewed arrival: stream0 fills, stream1 starts at cycle 6
      for (int i = 0; i < 4; i++) begin
         drive(2'b01, 2'b00, 64'h100 + 64'(i), 64'h0, 16'h0008, 16'h0);
         step();
         check("skew_no_valid_fill", 128'(m_valid), 128'(0));
      end
      check("skew_s_ready_full", 128'(s_ready), 128'(2'b10));
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      step();
      check("skew_no_valid_c4", 128'(m_valid), 128'(0));
      step();
      check("skew_no_valid_c5", 128'(m_valid), 128'(0));
      drive(2'b10, 2'b00, 64'h0, 64'h200, 16'h0, 16'h0018);
      step();
      check("skew_no_valid_c6", 128'(m_valid), 128'(0));
      for (int j = 0; j < 4; j++) begin
         if (j < 3) drive(2'b10, 2'b00, 64'h0, 64'h201 + 64'(j), 16'h0, 16'h0018);
         else       drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
         step();
         ea = 64'h100 + 64'(j);
         eb = 64'h200 + 64'(j);
         check("skew_valid", 128'(m_valid), 128'(1));
         check("skew_order", 128'(m_data), {eb, ea});
      end
      check("skew_user", 128'(m_user), 128'({16'h0018, 16'h0008}));
      step();
      check("skew_drain_valid", 128'(m_valid), 128'(0));
      check("skew_count", 128'(beat_count), 128'(5));

      // Backpressure hold
      m_ready = 1'b0;
      drive(2'b11, 2'b11, 64'h33, 64'h44, 16'h1238, 16'hABC8);
      step();
      drive(2'b11, 2'b00, 64'h55, 64'h66, 16'h0008, 16'h0008);
      step();
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      check("bp_valid", 128'(m_valid), 128'(1));
      for (int c = 0; c < 5; c++) begin
         step();
         check("bp_hold_valid", 128'(m_valid), 128'(1));
         check("bp_hold_data", 128'(m_data), {64'h44, 64'h33});
         check("bp_hold_user", 128'(m_user), 128'({16'hABC8, 16'h1238}));
         check("bp_hold_last", 128'(m_last), 128'(1));
      end
      m_ready = 1'b1;
      step();
      check("bp_next_data", 128'(m_data), {64'h66, 64'h55});
      check("bp_next_last", 128'(m_last), 128'(0));
      check("bp_count_mid", 128'(beat_count), 128'(6));
      step();
      check("bp_drain_valid", 128'(m_valid), 128'(0));
      check("bp_count", 128'(beat_count), 128'(7));

      // tlast disagreement
      check("err_clear_before", 128'(err_last_mismatch), 128'(0));
      drive(2'b11, 2'b01, 64'h77, 64'h88, 16'h0008, 16'h0008);
      step();
      drive(2'b11, 2'b11, 64'h99, 64'hAA, 16'h0008, 16'h0008);
      step();
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      check("mm_data", 128'(m_data), {64'h88, 64'h77});
      check("mm_last", 128'(m_last), 128'(0));
      check("mm_err_set", 128'(err_last_mismatch), 128'(1));
      step();
      check("mm_next_data", 128'(m_data), {64'hAA, 64'h99});
      check("mm_next_last", 128'(m_last), 128'(1));
      check("mm_err_sticky", 128'(err_last_mismatch), 128'(1));
      step();
      check("mm_err_sticky_idle", 128'(err_last_mismatch), 128'(1));
      check("mm_count", 128'(beat_count), 128'(9));

      // Reset with a buffered beat on stream0 only
      drive(2'b01, 2'b00, 64'hBB, 64'h0, 16'h0008, 16'h0);
      step();
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      areset = 1'b1;
      #1;
      check("midrst_err", 128'(err_last_mismatch), 128'(0));
      check("midrst_count", 128'(beat_count), 128'(0));
      check("midrst_s_ready", 128'(s_ready), 128'(2'b00));
      step();
      areset = 1'b0;
      step();
      check("midrst_release_ready", 128'(s_ready), 128'(2'b11));
      drive(2'b10, 2'b00, 64'h0, 64'hCC, 16'h0, 16'h0008);
      step();
      drive(2'b00, 2'b00, 64'h0, 64'h0, 16'h0, 16'h0);
      step();
      step();
      check("midrst_discarded", 128'(m_valid), 128'(0));
      check("midrst_data", 128'(m_data), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axis_stream_join.md
Name: axis_stream_join

Overview:
- Generalised successor to the pixels/weights stream synchroniser in the conv-engine input path.
- Joins NUM_S independent AXI-Stream inputs into one output beat: the pixel pipe, the weight rotator, and future streams such as bias or per-channel scale.
- Each input is decoupled by its own small FIFO, so one producer stalling never back-propagates combinationally into another.
- The output stage is registered. tlast is selected from one stream and cross-checked against the others. Selected tuser flags are gated with the output valid.

Parameters:
- NUM_S, 2, number of joined input streams (2..8).
- DATA_W, 64, tdata width per stream, in bits.
- USER_W, 16, tuser width per stream, in bits.
- FIFO_DEPTH, 4, entries per input FIFO; must be a power of 2 and at least 2.
- LAST_SRC, 1, index of the stream whose tlast drives m_last.
- LAST_CHECK, 1, when 1, tlast disagreement between streams raises the error flag.
- GATE_MASK, {USER_W{1'b0}}, bit i set means tuser bit i of every stream is ANDed with m_valid at the output.
- CNT_W, 32, width of the beat counter.

Ports:
- aclk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- s_valid  in  NUM_S  per-stream tvalid.
- s_ready  out  NUM_S  per-stream tready.
- s_last  in  NUM_S  per-stream tlast.
- s_data  in  NUM_S*DATA_W  stream k occupies bits [k*DATA_W +: DATA_W].
- s_user  in  NUM_S*USER_W  stream k occupies bits [k*USER_W +: USER_W].
- m_valid  out  1  joined beat valid.
- m_ready  in  1  downstream ready.
- m_last  out  1  tlast of stream LAST_SRC for the joined beat.
- m_data  out  NUM_S*DATA_W  concatenation of the joined stream beats, same packing as the inputs.
- m_user  out  NUM_S*USER_W  concatenated tuser with GATE_MASK bits gated.
- err_last_mismatch  out  1  sticky tlast-disagreement flag.
- beat_count  out  CNT_W  number of joined beats accepted downstream.

Behaviour:
- Reset (areset=1, asynchronous):
  - FIFOs are emptied.
  - m_valid, m_last, m_data, m_user, err_last_mismatch and beat_count are all 0.
  - s_ready is 0 while areset is high. It becomes 1 on the first aclk edge after release.
  - Reset asserted mid-transfer discards all buffered beats. No partial beat is emitted after release.
- Input side, stream k:
  - s_ready[k] is registered, equal to !full[k]. It never depends on m_ready or on other streams.
  - A push happens when s_valid[k] && s_ready[k].
  - The FIFO stores {last, user, data}.
  - When the FIFO is full, s_ready[k] is 0 even if a pop happens in the same cycle. Readiness returns on the next cycle.
- Join condition:
  - fire = (all FIFOs non-empty) && (!m_valid || m_ready).
  - On fire, every FIFO pops exactly one entry in the same cycle and the output register loads.
  - If fire is false, no FIFO pops. The join is all-or-nothing.
- Output register:
  - On fire, m_valid is set to 1.
  - Else, if m_valid && m_ready, m_valid is cleared to 0.
  - While m_valid && !m_ready, m_data, m_user and m_last hold stable.
- Latency:
  - A beat pushed at edge t is visible in its FIFO after t.
  - The earliest output is m_valid=1 after edge t+1, provided the other streams are already waiting.
  - Throughput is 1 beat/cycle in steady state.
- m_last: the stored last of stream LAST_SRC.
- m_user: for bit i of each stream, the output is user & (GATE_MASK[i] ? m_valid : 1). Gating is combinational on the registered m_valid.
- err_last_mismatch:
  - Set on fire when LAST_CHECK=1 and the popped last bits are neither all 0 nor all 1.
  - Sticky until reset. The beat is still delivered.
- beat_count:
  - Increments on m_valid && m_ready.
  - Wraps from 2^CNT_W-1 to 0 silently.
- Simultaneous push and pop on the same FIFO: allowed whenever not full. The count is unchanged.
- Degenerate case NUM_S=1: the block behaves as a registered FIFO slice. A mismatch is impossible.

Decomposition:
- Shared params package holds:
  - default NUM_S, DATA_W and USER_W taken from the existing UNITS/COPIES/WORD_WIDTH-derived widths;
  - GATE_MASK built from the conv tuser indices (top/bottom block, cols_1_k2, cin_last, w_first, col_valid, sum_start);
  - the clog2 helper for FIFO pointers.
- Sub-module axis_join_fifo:
  - one instance per stream, generated NUM_S times;
  - width 1+USER_W+DATA_W;
  - exposes full, empty and a registered s_ready.
- The join/output logic lives in the top module.

Test Plan:
- Reset release, NUM_S=2: all outputs read 0 during reset. s_ready reads 2'b11 one edge after release.
- Beat present on both streams, m_ready=1:
  - stream0 data=0x11, stream1 data=0x22, both pushed at edge 0;
  - expect m_valid=1 after edge 1, m_data={0x22,0x11}, beat_count becomes 1 after edge 2.
- Skewed arrival:
  - stream0 pushes 4 beats at cycles 0-3; stream1 pushes its first beat at cycle 6;
  - expect no m_valid before cycle 7;
  - expect s_ready[0]=0 after the 4th push with FIFO_DEPTH=4;
  - expect the output order to match the push order.
- Backpressure: hold m_ready=0 for 5 cycles while m_valid=1. m_data, m_user and m_last must stay constant, and no FIFO pops.
- Last mismatch, LAST_SRC=1, LAST_CHECK=1:
  - beat with s_last=2'b01;
  - expect m_last=0 and err_last_mismatch=1 after the fire edge, staying 1 through the following matched beats.
- Gating, with GATE_MASK bit 3 set and s_user bit 3=1 on every beat:
  - bit 3 of m_user is 0 whenever m_valid=0;
  - it equals 1 on valid beats;
  - ungated bits pass the stored value unchanged.
